// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : Reset and lock sequencer for the video/core PLL. Pulses the
//               PLL reset, waits for a synchronized lock, requires the lock
//               to stay up for LOCK_STABLE consecutive cycles, then releases
//               the core reset. Lock attempts that time out are retried, and
//               lock loss while running triggers a full resequence.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   refclk        in   reference clock (only clock)
//   rst           in   synchronous active-high reset
//   pll_locked    in   PLL lock indicator, asynchronous to refclk
//   relock_req    in   single-cycle request to force a relock (RUN only)
//   pll_rst       out  active-high reset to the PLL
//   core_rst      out  synchronous active-high reset for core logic
//   ready         out  high only in RUN
//   fault         out  high only in FAULT
//   relock_count  out  lock losses seen in RUN, saturating at 255
//   state         out  encoded FSM state (debug)
// ----------------------------------------------------------------------------
// Build option
//   PLLSEQ_FAULT_STOP_EN : when defined, MAX_RETRIES consecutive lock
//                          timeouts park the sequencer in FAULT until rst.
//                          When undefined, timeouts retry forever and fault
//                          is tied low.
// ============================================================================
module pll_reset_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 3,
    parameter int CNT_W        = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ready,
    output logic       fault,
    output logic [7:0] relock_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // Terminal counts: the counter starts at 0 on entry to each state, so
    // the last cycle of an N-cycle interval is at count N-1.
    localparam logic [CNT_W-1:0] c_rst_last     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_stable_last  = CNT_W'(LOCK_STABLE - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sync_q;
    logic [7:0]         rc_q, rc_d;
    logic               lk;

    // Two-flop synchronizer for the asynchronous lock indicator.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    assign lk = sync_q[1];

`ifdef PLLSEQ_FAULT_STOP_EN
    localparam logic [7:0] c_retry_last = 8'(MAX_RETRIES - 1);

    // Consecutive timeouts since the last successful entry into RUN.
    logic [7:0] attempts_q, attempts_d;

    always_ff @(posedge refclk) begin
        if (rst) begin
            attempts_q <= 8'd0;
        end else begin
            attempts_q <= attempts_d;
        end
    end
`else
    // Retry limit only matters when the fault stop is built in.
    logic w_unused_cfg;
    assign w_unused_cfg = (MAX_RETRIES != 0);
`endif

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= ST_PLL_RST;
            cnt_q   <= '0;
            rc_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        rc_d       = rc_q;
`ifdef PLLSEQ_FAULT_STOP_EN
        attempts_d = attempts_q;
`endif
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == c_rst_last) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == c_timeout_last) begin
                    cnt_d   = '0;
`ifdef PLLSEQ_FAULT_STOP_EN
                    attempts_d = attempts_q + 8'd1;
                    state_d    = (attempts_q == c_retry_last) ? ST_FAULT : ST_PLL_RST;
`else
                    state_d = ST_PLL_RST;
`endif
                end
            end
            ST_STABLE: begin
                // Any dropout restarts the stability window from zero.
                if (!lk) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == c_stable_last) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
`ifdef PLLSEQ_FAULT_STOP_EN
                    attempts_d = 8'd0;
`endif
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                // Lock loss takes precedence over an explicit relock request
                // so a coincident request still gets counted as a loss.
                if (!lk) begin
                    state_d = ST_PLL_RST;
                    rc_d    = (rc_q == 8'hFF) ? rc_q : rc_q + 8'd1;
                end else if (relock_req) begin
                    state_d = ST_PLL_RST;
                end
            end
`ifdef PLLSEQ_FAULT_STOP_EN
            ST_FAULT: begin
                cnt_d = cnt_q;
            end
`endif
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Moore output decode of the registered state.
    always_comb begin
        pll_rst  = 1'b0;
        core_rst = 1'b1;
        ready    = 1'b0;
        fault    = 1'b0;
        case (state_q)
            ST_PLL_RST: pll_rst = 1'b1;
            ST_RUN: begin
                core_rst = 1'b0;
                ready    = 1'b1;
            end
`ifdef PLLSEQ_FAULT_STOP_EN
            ST_FAULT: begin
                pll_rst = 1'b1;
                fault   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign relock_count = rc_q;
    assign state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Scoreboard bench for pll_reset_sequencer. Stimulus tasks push
//               cycle-tagged expectations; a monitor on the falling edge pops
//               and compares them when their cycle arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 20;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRIES  = 2;
    localparam int CNT_W        = 16;

    localparam int S_PLL_RST = 0;
    localparam int S_WAIT    = 1;
    localparam int S_STABLE  = 2;
    localparam int S_RUN     = 3;
    localparam int S_FAULT   = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, core_rst, ready, fault;
    logic [7:0] relock_count;
    logic [2:0] state;

    pll_reset_sequencer #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE),
        .MAX_RETRIES (MAX_RETRIES),
        .CNT_W       (CNT_W)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .relock_req  (relock_req),
        .pll_rst     (pll_rst),
        .core_rst    (core_rst),
        .ready       (ready),
        .fault       (fault),
        .relock_count(relock_count),
        .state       (state)
    );

    always #5 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        int    st;
        int    rc;
        string nm;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Expected {pll_rst, core_rst, ready, fault} for each state.
    function automatic logic [3:0] decode(input int st);
        case (st)
            S_PLL_RST: decode = 4'b1100;
            S_WAIT:    decode = 4'b0100;
            S_STABLE:  decode = 4'b0100;
            S_RUN:     decode = 4'b0010;
            S_FAULT:   decode = 4'b1101;
            default:   decode = 4'bxxxx;
        endcase
    endfunction

    task automatic expect_at(input int t, input int st, input int rc, input string nm);
        exp_t e;
        e.cyc = t;
        e.st  = st;
        e.rc  = rc;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    // Monitor: outputs are registered, so the falling edge is a stable
    // sampling point.
    always @(negedge refclk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t       e;
            logic [3:0] got_o, exp_o;
            e     = sb.pop_front();
            n_tests++;
            got_o = {pll_rst, core_rst, ready, fault};
            exp_o = decode(e.st);
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.nm, e.cyc, cyc);
            end else if (int'(state) != e.st || got_o !== exp_o || int'(relock_count) != e.rc) begin
                n_fail++;
                $display("FAIL %s @%0d: got state=%0d {pll_rst,core_rst,ready,fault}=%b rc=%0d, expected state=%0d outs=%b rc=%0d",
                         e.nm, cyc, state, got_o, relock_count, e.st, exp_o, e.rc);
            end
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge refclk);
    endtask

    // Holds rst for a few cycles, then releases it. Returns c0, the cycle
    // index of "cycle 0" (first cycle with rst low, state still reset).
    task automatic do_reset(input logic lock, output int c0);
        @(negedge refclk);
        rst        = 1'b1;
        pll_locked = lock;
        relock_req = 1'b0;
        @(negedge refclk);
        @(negedge refclk);
        expect_at(cyc + 1, S_PLL_RST, 0, "reset_state");
        @(negedge refclk);
        rst = 1'b0;
        c0  = cyc;
    endtask

    int c0, c, r, exp_rc;

    initial begin
        @(negedge refclk);

        // Power-up with lock already present.
        do_reset(1'b1, c0);
        expect_at(c0 + 3,  S_PLL_RST, 0, "pwr_pllrst_last");
        expect_at(c0 + 4,  S_WAIT,    0, "pwr_wait");
        expect_at(c0 + 5,  S_STABLE,  0, "pwr_stable_first");
        expect_at(c0 + 12, S_STABLE,  0, "pwr_stable_last");
        expect_at(c0 + 13, S_RUN,     0, "pwr_ready");
        wait_until(c0 + 15);

        // relock_req alone in RUN, then relock_req during STABLE.
        relock_req = 1'b1;
        r = cyc + 1;
        expect_at(r, S_PLL_RST, 0, "relock_req_run");
        @(negedge refclk);
        relock_req = 1'b0;
        wait_until(r + 7);
        relock_req = 1'b1;
        expect_at(r + 8, S_STABLE, 0, "relock_req_stable_ignored");
        expect_at(r + 12, S_STABLE, 0, "relock_req_stable_last");
        expect_at(r + 13, S_RUN, 0, "relock_req_reready");
        @(negedge refclk);
        relock_req = 1'b0;
        wait_until(r + 13);

        // One-cycle lock glitch during STABLE forces a full recount.
        do_reset(1'b1, c0);
        expect_at(c0 + 5, S_STABLE, 0, "glitch_stable");
        wait_until(c0 + 6);
        pll_locked = 1'b0;
        expect_at(c0 + 8,  S_STABLE, 0, "glitch_lk_low");
        expect_at(c0 + 9,  S_WAIT,   0, "glitch_back_wait");
        expect_at(c0 + 10, S_STABLE, 0, "glitch_restable");
        expect_at(c0 + 17, S_STABLE, 0, "glitch_recount_last");
        expect_at(c0 + 18, S_RUN,    0, "glitch_ready");
        @(negedge refclk);
        pll_locked = 1'b1;
        wait_until(c0 + 20);

        // Lock loss in RUN: reset reasserts 3 cycles after the input edge.
        c = cyc;
        pll_locked = 1'b0;
        expect_at(c + 2, S_RUN,     0, "loss_still_run");
        expect_at(c + 3, S_PLL_RST, 1, "loss_pll_rst");
        wait_until(c + 3);
        pll_locked = 1'b1;
        expect_at(c + 7,  S_WAIT, 1, "loss_wait");
        expect_at(c + 16, S_RUN,  1, "loss_reready");
        wait_until(c + 16);

        // relock_req coincident with lock loss counts exactly once.
        c = cyc;
        pll_locked = 1'b0;
        expect_at(c + 3,  S_PLL_RST, 2, "both_pll_rst");
        expect_at(c + 16, S_RUN,     2, "both_reready");
        wait_until(c + 2);
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        pll_locked = 1'b1;
        wait_until(c + 16);

        // 300 more losses: relock_count saturates at 255.
        exp_rc = 2;
        for (int i = 0; i < 300; i++) begin
            c = cyc;
            pll_locked = 1'b0;
            exp_rc = (exp_rc >= 255) ? 255 : exp_rc + 1;
            expect_at(c + 3, S_PLL_RST, exp_rc, "sat_loss");
            wait_until(c + 3);
            pll_locked = 1'b1;
            expect_at(c + 16, S_RUN, exp_rc, "sat_reready");
            wait_until(c + 16);
        end

        // Lock never arrives: timeout behaviour (reset also clears the count).
        do_reset(1'b0, c0);
        expect_at(c0 + 3,  S_PLL_RST, 0, "to_pllrst_1");
        expect_at(c0 + 4,  S_WAIT,    0, "to_wait_1");
        expect_at(c0 + 23, S_WAIT,    0, "to_wait_1_last");
        expect_at(c0 + 24, S_PLL_RST, 0, "to_pllrst_2");
        expect_at(c0 + 28, S_WAIT,    0, "to_wait_2");
        expect_at(c0 + 47, S_WAIT,    0, "to_wait_2_last");
`ifdef PLLSEQ_FAULT_STOP_EN
        expect_at(c0 + 48,  S_FAULT, 0, "to_fault");
        expect_at(c0 + 100, S_FAULT, 0, "to_fault_held");
        wait_until(c0 + 60);
        pll_locked = 1'b1;
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        wait_until(c0 + 100);
`else
        expect_at(c0 + 48,  S_PLL_RST, 0, "to_pllrst_3");
        expect_at(c0 + 72,  S_PLL_RST, 0, "to_pllrst_4");
        expect_at(c0 + 96,  S_PLL_RST, 0, "to_pllrst_5");
        expect_at(c0 + 100, S_WAIT,    0, "to_wait_5");
        wait_until(c0 + 100);
        pll_locked = 1'b1;
        expect_at(c0 + 103, S_STABLE, 0, "to_late_stable");
        expect_at(c0 + 111, S_RUN,    0, "to_late_ready");
        wait_until(c0 + 111);
`endif

        // Clean restart after reset.
        do_reset(1'b1, c0);
        expect_at(c0 + 3,  S_PLL_RST, 0, "restart_pllrst");
        expect_at(c0 + 12, S_STABLE,  0, "restart_stable_last");
        expect_at(c0 + 13, S_RUN,     0, "restart_ready");
        wait_until(c0 + 13);

        repeat (3) @(negedge refclk);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never checked", e.nm, e.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
